// File: rtl/player_ctrl.sv
// player_ctrl: two-player tile movement controller.
// Latches one pending move per player and commits it on frame_tick.
module player_ctrl #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int A_H0 = 1,
    parameter int A_V0 = 1,
    parameter int B_H0 = 8,
    parameter int B_V0 = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       frame_tick,
    output logic [3:0] curAh,
    output logic [3:0] curAv,
    output logic [3:0] curBh,
    output logic [3:0] curBv,
    output logic       moved_a,
    output logic       moved_b,
    output logic       blocked_a,
    output logic       blocked_b
);

    localparam logic [3:0] CD      = 4'(COOLDOWN_FRAMES);
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    logic [3:0] r_ah, r_av, r_bh, r_bv;
    logic       r_pa_v, r_pb_v;
    logic [1:0] r_pa_d, r_pb_d;
    logic [3:0] r_ca, r_cb;
    logic       r_moved_a, r_moved_b, r_blocked_a, r_blocked_b;

    logic       w_a_key, w_b_key;
    logic [1:0] w_a_dir, w_b_dir;
    logic [4:0] w_ta_h, w_ta_v, w_tb_h, w_tb_v;
    logic [3:0] w_na_h, w_na_v;
    logic       w_a_ok, w_b_ok;

    // Horizontal target, widened so 0-1 becomes 31 and 9+1 becomes 10.
    function automatic logic [4:0] step_h(input logic [3:0] h,
                                          input logic [1:0] d);
        case (d)
            D_LEFT:  return {1'b0, h} - 5'd1;
            D_RIGHT: return {1'b0, h} + 5'd1;
            default: return {1'b0, h};
        endcase
    endfunction

    function automatic logic [4:0] step_v(input logic [3:0] v,
                                          input logic [1:0] d);
        case (d)
            D_UP:    return {1'b0, v} - 5'd1;
            D_DOWN:  return {1'b0, v} + 5'd1;
            default: return {1'b0, v};
        endcase
    endfunction

    // In range, not a wall and not the other player's tile.
    function automatic logic legal(input logic [4:0] th, input logic [4:0] tv,
                                   input logic [3:0] oh, input logic [3:0] ov);
        logic in_rng, wall, hit;
        in_rng = (th <= 5'd9) && (tv <= 5'd5);
        wall   = ((th % 5'd3) != 5'd0) && (tv[1:0] == 2'b00);
        hit    = (th == {1'b0, oh}) && (tv == {1'b0, ov});
        return in_rng && !wall && !hit;
    endfunction

    // Decode make codes into per-player move requests.
    always_comb begin
        w_a_key = 1'b0;
        w_a_dir = D_UP;
        w_b_key = 1'b0;
        w_b_dir = D_UP;
        if (key_valid) begin
            case (key_code)
                9'h01D: begin w_a_key = 1'b1; w_a_dir = D_UP;    end
                9'h01C: begin w_a_key = 1'b1; w_a_dir = D_LEFT;  end
                9'h01B: begin w_a_key = 1'b1; w_a_dir = D_DOWN;  end
                9'h023: begin w_a_key = 1'b1; w_a_dir = D_RIGHT; end
                9'h175: begin w_b_key = 1'b1; w_b_dir = D_UP;    end
                9'h16B: begin w_b_key = 1'b1; w_b_dir = D_LEFT;  end
                9'h172: begin w_b_key = 1'b1; w_b_dir = D_DOWN;  end
                9'h174: begin w_b_key = 1'b1; w_b_dir = D_RIGHT; end
                default: ;
            endcase
        end
    end

    // Move checks: B is tested against A's already-updated position.
    always_comb begin
        w_ta_h = step_h(r_ah, r_pa_d);
        w_ta_v = step_v(r_av, r_pa_d);
        w_tb_h = step_h(r_bh, r_pb_d);
        w_tb_v = step_v(r_bv, r_pb_d);
        w_a_ok = legal(w_ta_h, w_ta_v, r_bh, r_bv);
        w_na_h = r_ah;
        w_na_v = r_av;
        if (frame_tick && r_ca == 4'd0 && r_pa_v && w_a_ok) begin
            w_na_h = w_ta_h[3:0];
            w_na_v = w_ta_v[3:0];
        end
        w_b_ok = legal(w_tb_h, w_tb_v, w_na_h, w_na_v);
    end

    // Frame-tick commit, cooldowns, pending latch and pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ah        <= 4'(A_H0);
            r_av        <= 4'(A_V0);
            r_bh        <= 4'(B_H0);
            r_bv        <= 4'(B_V0);
            r_pa_v      <= 1'b0;
            r_pb_v      <= 1'b0;
            r_pa_d      <= D_UP;
            r_pb_d      <= D_UP;
            r_ca        <= 4'd0;
            r_cb        <= 4'd0;
            r_moved_a   <= 1'b0;
            r_moved_b   <= 1'b0;
            r_blocked_a <= 1'b0;
            r_blocked_b <= 1'b0;
        end else begin
            r_moved_a   <= 1'b0;
            r_moved_b   <= 1'b0;
            r_blocked_a <= 1'b0;
            r_blocked_b <= 1'b0;
            if (frame_tick) begin
                if (r_ca != 4'd0) begin
                    r_ca <= r_ca - 4'd1;
                end else if (r_pa_v) begin
                    r_pa_v <= 1'b0;
                    if (w_a_ok) begin
                        r_ah      <= w_na_h;
                        r_av      <= w_na_v;
                        r_moved_a <= 1'b1;
                        r_ca      <= CD;
                    end else begin
                        r_blocked_a <= 1'b1;
                    end
                end
                if (r_cb != 4'd0) begin
                    r_cb <= r_cb - 4'd1;
                end else if (r_pb_v) begin
                    r_pb_v <= 1'b0;
                    if (w_b_ok) begin
                        r_bh      <= w_tb_h[3:0];
                        r_bv      <= w_tb_v[3:0];
                        r_moved_b <= 1'b1;
                        r_cb      <= CD;
                    end else begin
                        r_blocked_b <= 1'b1;
                    end
                end
            end
            // A key arriving with a tick becomes the next pending move.
            if (w_a_key) begin
                r_pa_v <= 1'b1;
                r_pa_d <= w_a_dir;
            end
            if (w_b_key) begin
                r_pb_v <= 1'b1;
                r_pb_d <= w_b_dir;
            end
        end
    end

    assign curAh     = r_ah;
    assign curAv     = r_av;
    assign curBh     = r_bh;
    assign curBv     = r_bv;
    assign moved_a   = r_moved_a;
    assign moved_b   = r_moved_b;
    assign blocked_a = r_blocked_a;
    assign blocked_b = r_blocked_b;

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: scoreboard bench for player_ctrl, two parameter sets.
// Expected outputs come from a tile-level model of the movement rules.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = 9'h000;
    logic       frame_tick = 1'b0;

    logic [3:0] ah0, av0, bh0, bv0, ah1, av1, bh1, bv1;
    logic       ma0, mb0, ba0, bb0, ma1, mb1, ba1, bb1;

    int n_checks = 0;
    int n_fail = 0;

    logic [23:0] exp_q[$];

    // model state, index 0 = default params, 1 = no cooldown, close start
    int m_ah[2], m_av[2], m_bh[2], m_bv[2];
    int m_ca[2], m_cb[2];
    bit m_pav[2], m_pbv[2];
    int m_pad[2], m_pbd[2];
    int cd_p[2] = '{4, 0};
    int rah[2] = '{1, 3};
    int rav[2] = '{1, 2};
    int rbh[2] = '{8, 5};
    int rbv[2] = '{5, 2};
    int dh[4] = '{0, -1, 0, 1};
    int dv[4] = '{-1, 0, 1, 0};
    logic [8:0] codes[10] = '{9'h01D, 9'h01C, 9'h01B, 9'h023,
                              9'h175, 9'h16B, 9'h172, 9'h174,
                              9'h11D, 9'h075};

    always #5 clk = ~clk;

    player_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid),
        .key_code(key_code), .frame_tick(frame_tick),
        .curAh(ah0), .curAv(av0), .curBh(bh0), .curBv(bv0),
        .moved_a(ma0), .moved_b(mb0), .blocked_a(ba0), .blocked_b(bb0)
    );

    player_ctrl #(
        .COOLDOWN_FRAMES(0), .A_H0(3), .A_V0(2), .B_H0(5), .B_V0(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid),
        .key_code(key_code), .frame_tick(frame_tick),
        .curAh(ah1), .curAv(av1), .curBh(bh1), .curBv(bv1),
        .moved_a(ma1), .moved_b(mb1), .blocked_a(ba1), .blocked_b(bb1)
    );

    function automatic bit free_tile(int h, int v, int oh, int ov);
        bit in_rng = h >= 0 && h <= 9 && v >= 0 && v <= 5;
        bit wall = (h % 3 != 0) && (v % 4 == 0);
        return in_rng && !wall && !(h == oh && v == ov);
    endfunction

    function automatic logic [23:0] pack(int k);
        return {4'(m_ah[k]), 4'(m_av[k]), 4'(m_bh[k]), 4'(m_bv[k]),
                8'h00};
    endfunction

    task automatic model_step(input int k, input bit rst, input bit kv,
                              input logic [8:0] kc, input bit ft);
        bit ma = 0, mb = 0, ba = 0, bb = 0;
        int th, tv;
        logic [23:0] e;
        if (rst) begin
            m_ah[k] = rah[k]; m_av[k] = rav[k];
            m_bh[k] = rbh[k]; m_bv[k] = rbv[k];
            m_ca[k] = 0; m_cb[k] = 0;
            m_pav[k] = 0; m_pbv[k] = 0;
        end else begin
            if (ft) begin
                if (m_ca[k] > 0) m_ca[k]--;
                else if (m_pav[k]) begin
                    th = m_ah[k] + dh[m_pad[k]];
                    tv = m_av[k] + dv[m_pad[k]];
                    if (free_tile(th, tv, m_bh[k], m_bv[k])) begin
                        m_ah[k] = th; m_av[k] = tv; ma = 1;
                        m_ca[k] = cd_p[k];
                    end else ba = 1;
                    m_pav[k] = 0;
                end
                if (m_cb[k] > 0) m_cb[k]--;
                else if (m_pbv[k]) begin
                    th = m_bh[k] + dh[m_pbd[k]];
                    tv = m_bv[k] + dv[m_pbd[k]];
                    if (free_tile(th, tv, m_ah[k], m_av[k])) begin
                        m_bh[k] = th; m_bv[k] = tv; mb = 1;
                        m_cb[k] = cd_p[k];
                    end else bb = 1;
                    m_pbv[k] = 0;
                end
            end
            if (kv) begin
                for (int i = 0; i < 8; i++) begin
                    if (kc == codes[i]) begin
                        if (i < 4) begin m_pav[k] = 1; m_pad[k] = i; end
                        else begin m_pbv[k] = 1; m_pbd[k] = i - 4; end
                    end
                end
            end
        end
        e = pack(k);
        e[7:0] = {1'b0, ma, 1'b0, mb, 1'b0, ba, 1'b0, bb};
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit kv, input logic [8:0] kc,
                         input bit ft);
        @(negedge clk);
        rst_n = !rst;
        key_valid = kv;
        key_code = kc;
        frame_tick = ft;
        for (int k = 0; k < 2; k++) model_step(k, rst, kv, kc, ft);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 9'h000, 0);
    endtask

    task automatic tick();
        cycle(0, 0, 9'h000, 1);
        idle(1);
    endtask

    task automatic key(input logic [8:0] kc);
        cycle(0, 1, kc, 0);
    endtask

    // Monitor: every edge yields one output record per instance.
    always @(posedge clk) begin
        logic [23:0] act, e;
        #1;
        if (exp_q.size() >= 2) begin
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                if (k == 0)
                    act = {ah0, av0, bh0, bv0, 1'b0, ma0, 1'b0, mb0,
                           1'b0, ba0, 1'b0, bb0};
                else
                    act = {ah1, av1, bh1, bv1, 1'b0, ma1, 1'b0, mb1,
                           1'b0, ba1, 1'b0, bb1};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL dut%0d t=%0t got=%h expected=%h",
                                 k, $time, act, e);
                end
            end
        end
    end

    initial begin
        int r;
        logic [8:0] kc;
        cycle(1, 0, 9'h000, 0);
        cycle(1, 0, 9'h000, 0);
        idle(2);
        tick(); tick(); tick();
        // A right, then cooldown holds the second move for 4 ticks
        key(9'h01D & 9'h000 | 9'h023);
        tick();
        key(9'h023);
        tick(); tick(); tick(); tick(); tick();
        // wall above A, B off the bottom edge, contention in dut1
        cycle(1, 0, 9'h000, 0);
        key(9'h01D);
        key(9'h172);
        tick();
        key(9'h023);
        key(9'h16B);
        tick();
        // B to column 9 then right is out of range
        cycle(1, 0, 9'h000, 0);
        key(9'h174);
        tick();
        repeat (4) tick();
        key(9'h174);
        tick();
        // key coincident with tick: S now, D later
        cycle(1, 0, 9'h000, 0);
        key(9'h01B);
        cycle(0, 1, 9'h023, 1);
        idle(1);
        repeat (5) tick();
        // reset with tick while pending and cooldown active
        key(9'h023);
        tick();
        key(9'h01B);
        key(9'h16B);
        tick();
        cycle(1, 0, 9'h000, 1);
        tick();
        idle(2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            kc = (r == 9) ? 9'($urandom) : codes[r];
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 2) == 0, kc,
                  $urandom_range(0, 3) == 0);
        end
        idle(2);
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Movement controller sitting directly upstream of the tile-map pixel generator. It consumes decoded keyboard events and owns the two player tile positions that drive `curAh/curAv/curBh/curBv` of the pixel stage. It latches one pending move per player and commits it only at a frame boundary, after range, wall, collision and cooldown checks. The displayed frame therefore never tears mid-scan.

## Interface
- `COOLDOWN_FRAMES`, 4: frames a player is frozen after a committed move (0..15; 0 = no cooldown).
- `A_H0`, 1 / `A_V0`, 1: player A reset tile.
- `B_H0`, 8 / `B_V0`, 5: player B reset tile.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `key_valid`  in  1  one-cycle pulse; `key_code` is valid this cycle.
- `key_code`  in  9  PS/2 make code, bit 8 = extended (E0) prefix.
- `frame_tick`  in  1  one-cycle pulse, once per frame, asserted during vertical blanking.
- `curAh`  out  4  player A column, 0..9.
- `curAv`  out  4  player A row, 0..5.
- `curBh`  out  4  player B column, 0..9.
- `curBv`  out  4  player B row, 0..5.
- `moved_a` / `moved_b`  out  1  one-cycle pulse: move committed this tick.
- `blocked_a` / `blocked_b`  out  1  one-cycle pulse: pending move rejected this tick.

## Operation
- Key map:
  - Player A: W 9'h01D up, A 9'h01C left, S 9'h01B down, D 9'h023 right.
  - Player B: 9'h175 up, 9'h16B left, 9'h172 down, 9'h174 right.
  - Any other code is ignored.
- Pending register per player: 1 valid bit plus 2-bit direction. A new key for that player overwrites the pending move (latest wins).
- Per-player cooldown counter, 4 bits.
- On `frame_tick`, player A is evaluated first, then player B:
  - Cooldown ≠ 0: decrement it; pending move is kept; no pulse.
  - Cooldown = 0 and pending valid: compute the target tile. The move is rejected if any of the following holds:
    - target column outside 0..9, or target row outside 0..5 (no wrap);
    - target is a wall tile, i.e. (h mod 3 ≠ 0) and (v mod 4 = 0);
    - target equals the other player's position. For B, "other position" means A's position after A's update in this same tick.
  - Accept: update position, pulse `moved_x`, load cooldown with `COOLDOWN_FRAMES`.
  - Reject: position is held, pulse `blocked_x`.
  - In both cases pending is cleared.
  - Pending invalid: nothing happens.
- A and B both targeting the same free tile in one tick: A wins and B is blocked.
- A and B swapping tiles: A is blocked (B occupies its target), then B is blocked (A is still at B's target).
- Walls and water: water tiles (h mod 3 = 0) are passable. Reset tiles must be non-wall and distinct from each other.
- Arithmetic: compute targets in 5-bit signed/extended form so that 0−1 and 9+1 are detected as out of range, never wrapped.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - positions load `A_H0/A_V0/B_H0/B_V0`;
  - pending valid cleared, cooldowns = 0;
  - all pulse outputs 0.
  - Reset takes priority over `frame_tick` and `key_valid` in the same cycle. A mid-frame reset discards any pending moves.
- `key_valid` at edge n: pending is updated at edge n and is eligible at the first `frame_tick` at edge > n.
- `key_valid` and `frame_tick` in the same cycle: the tick evaluates the old pending; the new key then becomes the pending value. This key is not lost.
- Commit latency: position outputs change on the `clk` edge sampling `frame_tick`. `moved_x`/`blocked_x` are high for exactly that one following cycle.
- All outputs are registered; there is no combinational path from input to output.
- `frame_tick` asserted on consecutive cycles: each cycle is treated as a separate tick (no edge detection).

## Test plan
- Reset then idle: positions A=(1,1), B=(8,5), all pulses 0; after 3 ticks with no keys, still unchanged.
- A presses D (01D→023), then tick: A=(2,1), `moved_a`=1 for 1 cycle. Press D again, then 4 ticks: no move (cooldown 4→0), pending kept; 5th tick: A=(3,1).
- Wall and range checks:
  - From A=(1,1), press W: target (1,0) is a wall → `blocked_a`, A stays (1,1).
  - B at (8,5) presses 9'h172 (down): out of range → `blocked_b`.
  - B at (9,5) presses 9'h174 (right): out of range → `blocked_b`.
- Contention: A at (3,2), B at (5,2), COOLDOWN_FRAMES=0. A presses D, B presses 9'h16B, same tick: A=(4,2) with `moved_a`; B stays (5,2) with `blocked_b`.
- Same-cycle key and tick: pending A=S, then `key_valid` with D coincident with a tick. S is applied this tick; D is applied at the next eligible tick.
- Reset mid-operation: pending moves and cooldown 3 active, assert `rst_n`=0 for 1 cycle coincident with `frame_tick`. Result: reset positions, no pulses, next tick without keys produces no move.
